// File: rtl/jtcps1_pal_loader.sv
`default_nettype none
// ============================================================================
// Module   : jtcps1_pal_loader
// Purpose  : Copies palette pages from VRAM into the palette RAM during
//            vertical blank. One VRAM word is read per palette entry. Traffic
//            only starts while VB is high. VB is checked again before every
//            entry, so a copy spread over several frames carries on where it
//            stopped.
//
// Ports    : rst          synchronous active-high reset
//            clk          single clock, rising edge
//            VB           vertical blank (high = copy allowed)
//            pal_copy     one-cycle copy request
//            pal_base     VRAM word address bits [16:11] of the palette
//            page_en      per-page enable, a low bit skips that page
//            vram_addr    VRAM word address
//            vram_cs      VRAM read request, held until vram_ok
//            vram_ok      read acknowledge, vram_data valid when high
//            vram_data    VRAM read data
//            pal_we       palette write strobe, one cycle per entry
//            pal_wr_addr  {page[2:0], index[8:0]}
//            pal_wr_data  {bright[3:0], r[3:0], g[3:0], b[3:0]}
//            busy         high from request acceptance to last write
//
// Revision : 1.0  initial release
// ============================================================================
module jtcps1_pal_loader #(
    parameter int PAGES   = 6,
    parameter int PAGE_AW = 9
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        VB,
    input  logic        pal_copy,
    input  logic [5:0]  pal_base,
    input  logic [5:0]  page_en,
    output logic [16:0] vram_addr,
    output logic        vram_cs,
    input  logic        vram_ok,
    input  logic [15:0] vram_data,
    output logic        pal_we,
    output logic [11:0] pal_wr_addr,
    output logic [15:0] pal_wr_data,
    output logic        busy
);

    // Page counter width. Three bits cover the six pages of the port map.
    localparam int                  c_PG_W      = 3;
    localparam int                  c_OFS_W     = c_PG_W + PAGE_AW;
    localparam logic [c_PG_W-1:0]   c_LAST_PAGE = c_PG_W'(PAGES - 1);
    localparam logic [PAGE_AW-1:0]  c_LAST_IDX  = {PAGE_AW{1'b1}};
    localparam logic [c_PG_W-1:0]   c_PG_ONE    = c_PG_W'(1);
    localparam logic [PAGE_AW-1:0]  c_IDX_ONE   = PAGE_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VB = 3'd1,
        S_READ    = 3'd2,
        S_WRITE   = 3'd3,
        S_NEXT    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;

    // Copy parameters latched at acceptance. Later changes on the inputs
    // only reach the next copy.
    logic [5:0]           r_base;
    logic [5:0]           r_page_en;
    logic [c_PG_W-1:0]    r_page;
    logic [PAGE_AW-1:0]   r_index;
    logic [15:0]          r_data;
    logic                 r_pending;

    logic [7:0]           w_en_ext;
    logic                 w_page_on;
    logic [c_OFS_W-1:0]   w_offset;

    // Control strobes from the next-state logic to the datapath
    logic                 w_start;
    logic                 w_capture;
    logic                 w_idx_inc;
    logic                 w_page_inc;

    // The enable vector is widened so that any page-counter value selects a
    // defined bit. Page numbers above 5 read as disabled.
    assign w_en_ext  = {2'b00, r_page_en};
    assign w_page_on = w_en_ext[r_page];
    assign w_offset  = {r_page, r_index};

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_capture  = 1'b0;
        w_idx_inc  = 1'b0;
        w_page_inc = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (pal_copy) begin
                    w_start    = 1'b1;
                    w_state_nx = S_WAIT_VB;
                end
            end

            S_WAIT_VB: begin
                // A disabled page goes straight to NEXT. It is skipped
                // without any VRAM access.
                if (VB) begin
                    w_state_nx = w_page_on ? S_READ : S_NEXT;
                end
            end

            S_READ: begin
                // VB is not checked here. An entry that was started always
                // completes.
                if (vram_ok) begin
                    w_capture  = 1'b1;
                    w_state_nx = S_WRITE;
                end
            end

            S_WRITE: begin
                w_state_nx = S_NEXT;
            end

            S_NEXT: begin
                if (w_page_on && (r_index != c_LAST_IDX)) begin
                    w_idx_inc  = 1'b1;
                    w_state_nx = S_WAIT_VB;
                end else if (r_page != c_LAST_PAGE) begin
                    w_page_inc = 1'b1;
                    w_state_nx = S_WAIT_VB;
                end else if (r_pending || pal_copy) begin
                    // Merged requests restart here with freshly latched
                    // inputs, so busy never drops between the two copies.
                    w_start    = 1'b1;
                    w_state_nx = S_WAIT_VB;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_base    <= 6'd0;
            r_page_en <= 6'd0;
            r_page    <= '0;
            r_index   <= '0;
            r_data    <= 16'd0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (w_start) begin
                r_base    <= pal_base;
                r_page_en <= page_en;
                r_page    <= '0;
                r_index   <= '0;
            end else if (w_page_inc) begin
                r_page  <= r_page + c_PG_ONE;
                r_index <= '0;
            end else if (w_idx_inc) begin
                r_index <= r_index + c_IDX_ONE;
            end

            if (w_capture) begin
                r_data <= vram_data;
            end

            // A single pending flag. Any number of requests made during a
            // copy merge into one.
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (pal_copy && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Address and request come straight from registered state. They stay
    // stable for the whole time READ waits on vram_ok.
    assign vram_cs     = (r_state == S_READ);
    assign vram_addr   = {r_base, 11'd0} + 17'(w_offset);
    assign pal_we      = (r_state == S_WRITE);
    assign pal_wr_addr = 12'(w_offset);
    assign pal_wr_data = r_data;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jtcps1_pal_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcps1_pal_loader
// Purpose  : Self-checking bench for jtcps1_pal_loader. The expected palette
//            writes go into a queue when each copy is requested. A monitor
//            compares each VRAM request and palette write against the head
//            of that queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtcps1_pal_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        VB;
    logic        pal_copy;
    logic [5:0]  pal_base;
    logic [5:0]  page_en;
    logic [16:0] vram_addr;
    logic        vram_cs;
    logic        vram_ok;
    logic [15:0] vram_data;
    logic        pal_we;
    logic [11:0] pal_wr_addr;
    logic [15:0] pal_wr_data;
    logic        busy;

    always #5 clk = ~clk;

    jtcps1_pal_loader #(.PAGES(6), .PAGE_AW(9)) dut (
        .rst         (rst),
        .clk         (clk),
        .VB          (VB),
        .pal_copy    (pal_copy),
        .pal_base    (pal_base),
        .page_en     (page_en),
        .vram_addr   (vram_addr),
        .vram_cs     (vram_cs),
        .vram_ok     (vram_ok),
        .vram_data   (vram_data),
        .pal_we      (pal_we),
        .pal_wr_addr (pal_wr_addr),
        .pal_wr_data (pal_wr_data),
        .busy        (busy)
    );

    typedef struct packed {
        logic [16:0] vaddr;
        logic [11:0] waddr;
    } exp_t;

    exp_t sb_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   n_wr      = 0;
    int   n_cs      = 0;
    int   lat       = 1;
    int   stray_cnt = 0;

    // VRAM contents: an address-dependent pattern
    function automatic logic [15:0] vmem(input logic [16:0] a);
        logic [16:0] m;
        m = a * 17'd3;
        return m[15:0] ^ 16'hC35A;
    endfunction

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_copy(input logic [5:0] base, input logic [5:0] en);
        exp_t e;
        for (int p = 0; p < 6; p++) begin
            if (en[p]) begin
                for (int i = 0; i < 512; i++) begin
                    e.waddr = 12'(p * 512 + i);
                    e.vaddr = {base, 11'd0} + 17'(p * 512 + i);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic pulse_copy(input logic [5:0] base, input logic [5:0] en);
        @(negedge clk);
        pal_base = base;
        page_en  = en;
        pal_copy = 1'b1;
        @(negedge clk);
        pal_copy = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40000 && busy; i++) @(negedge clk);
        chk(!busy, name, longint'(busy), 0);
    endtask

    task automatic wait_cs_after(input int c0, input string name);
        for (int i = 0; i < 500 && n_cs == c0; i++) @(negedge clk);
        chk(n_cs != c0, name, n_cs, c0 + 1);
    endtask

    task automatic wait_writes(input int w0, input int n, input string name);
        for (int i = 0; i < 40000 && (n_wr - w0) < n; i++) @(negedge clk);
        chk((n_wr - w0) >= n, name, n_wr - w0, n);
    endtask

    task automatic wait_cs_high(input string name);
        for (int i = 0; i < 200 && !vram_cs; i++) @(negedge clk);
        chk(vram_cs, name, longint'(vram_cs), 1);
    endtask

    // VRAM model: acknowledges a request lat cycles after it appears
    initial begin : vram_model
        int cnt;
        int stray_seen;
        cnt        = 0;
        stray_seen = 0;
        vram_ok    = 1'b0;
        vram_data  = 16'd0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                vram_ok    = 1'b1;
                vram_data  = 16'hDEAD;
                cnt        = 0;
            end else if (vram_cs && !vram_ok) begin
                cnt++;
                if (cnt >= lat) begin
                    vram_ok   = 1'b1;
                    vram_data = vmem(vram_addr);
                    cnt       = 0;
                end
            end else begin
                vram_ok = 1'b0;
                cnt     = 0;
            end
        end
    end

    // Monitor: checks each request and each write against the queue head
    initial begin : monitor
        logic        prev_cs;
        logic        prev_we;
        logic [16:0] prev_addr;
        exp_t        e;
        prev_cs   = 1'b0;
        prev_we   = 1'b0;
        prev_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (vram_cs && !prev_cs) begin
                n_cs++;
                chk(VB, "cs_while_vb_low", longint'(VB), 1);
                if (sb_q.size() == 0) begin
                    chk(1'b0, "cs_unexpected", vram_addr, 0);
                end else begin
                    chk(vram_addr === sb_q[0].vaddr, "cs_addr",
                        vram_addr, sb_q[0].vaddr);
                end
            end else if (vram_cs && prev_cs) begin
                chk(vram_addr === prev_addr, "cs_addr_stable",
                    vram_addr, prev_addr);
            end
            if (pal_we) begin
                n_wr++;
                chk(!prev_we, "we_one_cycle", longint'(prev_we), 0);
                if (sb_q.size() == 0) begin
                    chk(1'b0, "we_unexpected", pal_wr_addr, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk(pal_wr_addr === e.waddr, "wr_addr", pal_wr_addr, e.waddr);
                    chk(pal_wr_data === vmem(e.vaddr), "wr_data",
                        pal_wr_data, vmem(e.vaddr));
                end
            end
            prev_cs   = vram_cs;
            prev_we   = pal_we;
            prev_addr = vram_addr;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  w0;
        int  c0;
        int  w1;
        bit  saw;
        rst      = 1'b1;
        VB       = 1'b0;
        pal_copy = 1'b0;
        pal_base = 6'd0;
        page_en  = 6'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk(busy === 1'b0,          "rst_busy",   busy, 0);
        chk(vram_cs === 1'b0,       "rst_cs",     vram_cs, 0);
        chk(pal_we === 1'b0,        "rst_we",     pal_we, 0);
        chk(vram_addr === 17'd0,    "rst_vaddr",  vram_addr, 0);
        chk(pal_wr_addr === 12'd0,  "rst_waddr",  pal_wr_addr, 0);
        chk(pal_wr_data === 16'd0,  "rst_wdata",  pal_wr_data, 0);
        rst = 1'b0;

        // Full copy, all pages, one-cycle acknowledge
        VB  = 1'b1;
        lat = 1;
        push_copy(6'h12, 6'h3F);
        w0 = n_wr;
        c0 = n_cs;
        pulse_copy(6'h12, 6'h3F);
        chk(busy === 1'b1, "t1_busy_accept", busy, 1);
        wait_cs_after(c0, "t1_cs_timeout");
        chk(vram_addr === 17'h09000, "t1_first_vaddr", vram_addr, 17'h09000);
        wait_idle("t1_idle_timeout");
        chk(n_wr - w0 == 3072, "t1_write_count", n_wr - w0, 3072);
        chk(sb_q.size() == 0, "t1_queue_empty", sb_q.size(), 0);

        // Alternate pages disabled
        push_copy(6'h12, 6'b101010);
        w0 = n_wr;
        c0 = n_cs;
        pulse_copy(6'h12, 6'b101010);
        wait_idle("t2_idle_timeout");
        chk(n_wr - w0 == 1536, "t2_write_count", n_wr - w0, 1536);
        chk(n_cs - c0 == 1536, "t2_cs_count", n_cs - c0, 1536);
        chk(sb_q.size() == 0, "t2_queue_empty", sb_q.size(), 0);

        // VB drops during entry 101 with slow acknowledge
        lat = 5;
        push_copy(6'h05, 6'h3F);
        w0 = n_wr;
        pulse_copy(6'h05, 6'h3F);
        wait_writes(w0, 100, "t3_100_timeout");
        wait_cs_high("t3_cs_timeout");
        VB = 1'b0;
        wait_writes(w0, 101, "t3_101_timeout");
        lat = 1;
        c0  = n_cs;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (vram_cs) saw = 1'b1;
        end
        chk(!saw, "t3_no_cs_vb_low", longint'(saw), 0);
        chk(n_wr - w0 == 101, "t3_paused_writes", n_wr - w0, 101);
        VB = 1'b1;
        wait_cs_after(c0, "t3_resume_timeout");
        chk(vram_addr === 17'h02865, "t3_resume_vaddr", vram_addr, 17'h02865);
        wait_idle("t3_idle_timeout");
        chk(sb_q.size() == 0, "t3_queue_empty", sb_q.size(), 0);

        // Two requests during a copy merge into one extra copy
        push_copy(6'h12, 6'h3F);
        w0 = n_wr;
        pulse_copy(6'h12, 6'h3F);
        wait_writes(w0, 50, "t4_50_timeout");
        push_copy(6'h20, 6'h3F);
        pulse_copy(6'h20, 6'h3F);
        repeat (7) @(negedge clk);
        pulse_copy(6'h20, 6'h3F);
        wait_writes(w0, 3072, "t4_first_timeout");
        c0  = n_cs;
        saw = 1'b0;
        for (int i = 0; i < 500 && n_cs == c0; i++) begin
            if (!busy) saw = 1'b1;
            @(negedge clk);
        end
        chk(!saw, "t4_busy_between", longint'(saw), 0);
        chk(n_cs != c0, "t4_restart_timeout", n_cs, c0 + 1);
        chk(vram_addr === 17'h10000, "t4_second_vaddr", vram_addr, 17'h10000);
        wait_idle("t4_idle_timeout");
        repeat (20) @(negedge clk);
        chk(n_wr - w0 == 6144, "t4_one_extra_copy", n_wr - w0, 6144);
        chk(sb_q.size() == 0, "t4_queue_empty", sb_q.size(), 0);

        // Request with VB low, then reset during a read
        VB = 1'b0;
        push_copy(6'h03, 6'h3F);
        w0 = n_wr;
        c0 = n_cs;
        pulse_copy(6'h03, 6'h3F);
        chk(busy === 1'b1, "t5_busy_vb_low", busy, 1);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vram_cs) saw = 1'b1;
        end
        chk(!saw && n_cs == c0, "t5_no_traffic", n_cs - c0, 0);
        VB = 1'b1;
        wait_writes(w0, 20, "t5_20_timeout");
        wait_cs_high("t5_cs_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk(vram_cs === 1'b0,       "t5_rst_cs",    vram_cs, 0);
        chk(busy === 1'b0,          "t5_rst_busy",  busy, 0);
        chk(pal_we === 1'b0,        "t5_rst_we",    pal_we, 0);
        chk(vram_addr === 17'd0,    "t5_rst_vaddr", vram_addr, 0);
        chk(pal_wr_addr === 12'd0,  "t5_rst_waddr", pal_wr_addr, 0);
        rst = 1'b0;
        sb_q.delete();
        w1 = n_wr;
        stray_cnt++;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (vram_cs || busy || pal_we) saw = 1'b1;
        end
        chk(!saw, "t5_stray_ok_ignored", longint'(saw), 0);
        chk(n_wr == w1, "t5_no_write_after_rst", n_wr - w1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
